// File: rtl/cdb_writeback.sv
// Writeback stage: round-robin arbitration of FU results onto a registered CDB,
// register-file write on tag match, and the rd -> producing-tag status table.
module cdb_writeback #(
  parameter int NUM_SRC = 3,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC-1:0]       src_valid,
  output logic [NUM_SRC-1:0]       src_ready,
  input  logic [NUM_SRC*TAG_W-1:0] src_tag,
  input  logic [NUM_SRC*XLEN-1:0]  src_data,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_rd,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic                     flush,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [XLEN-1:0]          cdb_data,
  output logic                     Reg_writevalid,
  output logic [4:0]               Reg_writeaddr,
  output logic [31:0]              Reg_writedata,
  input  logic [4:0]               qry_addr1,
  output logic                     qry_busy1,
  output logic [TAG_W-1:0]         qry_tag1,
  input  logic [4:0]               qry_addr2,
  output logic                     qry_busy2,
  output logic [TAG_W-1:0]         qry_tag2
);

  localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [31:0]       busy_q, busy_d;
  logic [TAG_W-1:0]  tag_q [32];
  logic [TAG_W-1:0]  tag_d [32];
  logic              s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [XLEN-1:0]   s1_data_q, s1_data_d;
  logic [RR_W-1:0]   rr_q, rr_d;

  logic              found;
  logic              grant_ok;
  logic [RR_W-1:0]   cand;
  logic [RR_W-1:0]   gidx;
  logic [TAG_W-1:0]  sel_tag;
  logic [XLEN-1:0]   sel_data;
  logic              wb_hit;
  logic [4:0]        wb_addr;

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    gidx  = rr_q;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = RR_W'((int'(rr_q) + k) % NUM_SRC);
      if (!found && src_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    grant_ok  = found & rst_n & ~flush;
    src_ready = '0;
    sel_tag   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gidx == RR_W'(i)) begin
        sel_tag      = src_tag[i*TAG_W +: TAG_W];
        sel_data     = src_data[i*XLEN +: XLEN];
        src_ready[i] = grant_ok;
      end
    end
  end

  // Descending scan so the lowest matching register wins.
  always_comb begin
    wb_hit  = 1'b0;
    wb_addr = '0;
    for (int r = 31; r >= 1; r--) begin
      if (s1_valid_q && busy_q[r] && (tag_q[r] == s1_tag_q)) begin
        wb_hit  = 1'b1;
        wb_addr = 5'(r);
      end
    end
    Reg_writevalid = wb_hit & ~flush;
    Reg_writeaddr  = Reg_writevalid ? wb_addr : 5'd0;
    Reg_writedata  = Reg_writevalid ? 32'(s1_data_q) : 32'd0;
  end

  // Issue is applied after the writeback clear so a same-cycle rename wins.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wb_hit) busy_d[wb_addr] = 1'b0;
      if (issue_valid && (issue_rd != 5'd0)) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_tag;
      end
    end
    s1_valid_d = grant_ok;
    s1_tag_d   = grant_ok ? sel_tag : '0;
    s1_data_d  = grant_ok ? sel_data : '0;
    rr_d       = grant_ok ? gidx : rr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      for (int i = 0; i < 32; i++) tag_q[i] <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_data_q  <= '0;
      rr_q       <= RR_W'(NUM_SRC - 1);
    end else begin
      busy_q     <= busy_d;
      for (int i = 0; i < 32; i++) tag_q[i] <= tag_d[i];
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s1_data_q  <= s1_data_d;
      rr_q       <= rr_d;
    end
  end

  assign cdb_valid = s1_valid_q;
  assign cdb_tag   = s1_tag_q;
  assign cdb_data  = s1_data_q;

  assign qry_busy1 = busy_q[qry_addr1] & (qry_addr1 != 5'd0);
  assign qry_tag1  = (qry_addr1 == 5'd0) ? '0 : tag_q[qry_addr1];
  assign qry_busy2 = busy_q[qry_addr2] & (qry_addr2 != 5'd0);
  assign qry_tag2  = (qry_addr2 == 5'd0) ? '0 : tag_q[qry_addr2];

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed scenarios plus random traffic against a table-level reference model.
module tb_cdb_writeback;

  localparam int N  = 3;
  localparam int TW = 4;
  localparam int XW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*TW-1:0] src_tag;
  logic [N*XW-1:0] src_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [TW-1:0]   issue_tag;
  logic            flush;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [XW-1:0]   cdb_data;
  logic            Reg_writevalid;
  logic [4:0]      Reg_writeaddr;
  logic [31:0]     Reg_writedata;
  logic [4:0]      qry_addr1, qry_addr2;
  logic            qry_busy1, qry_busy2;
  logic [TW-1:0]   qry_tag1, qry_tag2;

  int n_cmp = 0;
  int n_err = 0;

  bit          m_busy [32];
  int          m_tag  [32];
  bit          m_s1v;
  int          m_s1tag;
  logic [31:0] m_s1data;
  int          m_last;

  cdb_writeback #(.NUM_SRC(N), .TAG_W(TW), .XLEN(XW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_tag(src_tag), .src_data(src_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .Reg_writevalid(Reg_writevalid), .Reg_writeaddr(Reg_writeaddr), .Reg_writedata(Reg_writedata),
    .qry_addr1(qry_addr1), .qry_busy1(qry_busy1), .qry_tag1(qry_tag1),
    .qry_addr2(qry_addr2), .qry_busy2(qry_busy2), .qry_tag2(qry_tag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_busy[r] = 1'b0;
      m_tag[r]  = 0;
    end
    m_s1v    = 1'b0;
    m_s1tag  = 0;
    m_s1data = '0;
    m_last   = N - 1;
  endfunction

  function automatic int exp_grant();
    if (!rst_n || flush) return -1;
    for (int k = 1; k <= N; k++)
      if (src_valid[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  function automatic int exp_hit();
    if (!m_s1v) return 0;
    for (int r = 1; r < 32; r++)
      if (m_busy[r] && m_tag[r] == m_s1tag) return r;
    return 0;
  endfunction

  task automatic check_all();
    int g, h;
    logic [N-1:0] er;
    bit wv;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("src_ready", 64'(src_ready), 64'(er));
    chk("cdb_valid", 64'(cdb_valid), 64'(m_s1v));
    if (m_s1v) begin
      chk("cdb_tag", 64'(cdb_tag), 64'(m_s1tag));
      chk("cdb_data", 64'(cdb_data), 64'(m_s1data));
    end
    h  = exp_hit();
    wv = (h != 0) && !flush;
    chk("reg_wv", 64'(Reg_writevalid), 64'(wv));
    chk("reg_wa", 64'(Reg_writeaddr), wv ? 64'(h) : 64'd0);
    chk("reg_wd", 64'(Reg_writedata), wv ? 64'(m_s1data) : 64'd0);
    chk("qry_busy1", 64'(qry_busy1), 64'(m_busy[qry_addr1]));
    chk("qry_busy2", 64'(qry_busy2), 64'(m_busy[qry_addr2]));
    if (m_busy[qry_addr1] || qry_addr1 == 0) chk("qry_tag1", 64'(qry_tag1), 64'(m_tag[qry_addr1]));
    if (m_busy[qry_addr2] || qry_addr2 == 0) chk("qry_tag2", 64'(qry_tag2), 64'(m_tag[qry_addr2]));
  endtask

  task automatic model_edge();
    int g, h;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g = exp_grant();
    h = exp_hit();
    if (flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    end else begin
      if (h != 0) m_busy[h] = 1'b0;
      if (issue_valid && issue_rd != 0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = int'(issue_tag);
      end
    end
    if (g >= 0) begin
      m_s1v    = 1'b1;
      m_s1tag  = int'(src_tag[g*TW +: TW]);
      m_s1data = src_data[g*XW +: XW];
      m_last   = g;
    end else begin
      m_s1v = 1'b0;
    end
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    src_valid   = '0;
    src_tag     = '0;
    src_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_tag   = '0;
    flush       = 1'b0;
    qry_addr1   = '0;
    qry_addr2   = '0;
  endtask

  task automatic set_src(input int i, input logic [TW-1:0] t, input logic [XW-1:0] d);
    src_valid[i]          = 1'b1;
    src_tag[i*TW +: TW]   = t;
    src_data[i*XW +: XW]  = d;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [TW-1:0] t);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_tag   = t;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    src_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_reg_wv", 64'(Reg_writevalid), 64'd0);
    chk("rst_qry_busy", 64'(qry_busy1), 64'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // single source: x5 renamed to tag 3, then ALU completes tag 3
    issue(5'd5, 4'd3);
    step();
    idle();
    set_src(0, 4'd3, 32'h0000_00AA);
    #1 chk("t1_ready", 64'(src_ready), 64'b001);
    step();
    idle();
    qry_addr1 = 5'd5;
    #1;
    chk("t1_cdb_valid", 64'(cdb_valid), 64'd1);
    chk("t1_cdb_tag", 64'(cdb_tag), 64'd3);
    chk("t1_reg_wv", 64'(Reg_writevalid), 64'd1);
    chk("t1_reg_wa", 64'(Reg_writeaddr), 64'd5);
    chk("t1_reg_wd", 64'(Reg_writedata), 64'hAA);
    step();
    #1 chk("t1_x5_free", 64'(qry_busy1), 64'd0);
    step();

    // round-robin from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 4'(i + 1), 32'(100 + i));
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rr_grant", 64'(src_ready), 64'(1 << (c % 3)));
      if (c > 0) chk("rr_cdb_tag", 64'(cdb_tag), 64'((c - 1) % 3 + 1));
      step();
    end
    idle();
    step();

    // renamed destination
    issue(5'd7, 4'd4);
    step();
    issue(5'd7, 4'd9);
    step();
    idle();
    set_src(1, 4'd4, 32'h44);
    step();
    idle();
    qry_addr1 = 5'd7;
    #1;
    chk("ren_cdb_tag", 64'(cdb_tag), 64'd4);
    chk("ren_reg_wv", 64'(Reg_writevalid), 64'd0);
    chk("ren_busy", 64'(qry_busy1), 64'd1);
    chk("ren_tag", 64'(qry_tag1), 64'd9);
    step();

    // same-cycle writeback and rename of x6
    issue(5'd6, 4'd2);
    step();
    idle();
    set_src(2, 4'd2, 32'h66);
    step();
    idle();
    issue(5'd6, 4'd8);
    #1;
    chk("col_reg_wv", 64'(Reg_writevalid), 64'd1);
    chk("col_reg_wa", 64'(Reg_writeaddr), 64'd6);
    step();
    idle();
    qry_addr2 = 5'd6;
    #1;
    chk("col_busy", 64'(qry_busy2), 64'd1);
    chk("col_tag", 64'(qry_tag2), 64'd8);
    step();

    // x0 is never renamed
    issue(5'd0, 4'd5);
    step();
    idle();
    set_src(0, 4'd5, 32'h55);
    #1;
    chk("x0_busy", 64'(qry_busy1), 64'd0);
    chk("x0_tag", 64'(qry_tag1), 64'd0);
    step();
    idle();
    #1;
    chk("x0_cdb_tag", 64'(cdb_tag), 64'd5);
    chk("x0_reg_wv", 64'(Reg_writevalid), 64'd0);
    step();

    // flush while tag 6 (x3) is broadcasting
    issue(5'd3, 4'd6);
    step();
    idle();
    set_src(0, 4'd6, 32'h33);
    step();
    idle();
    flush = 1'b1;
    set_src(1, 4'd7, 32'h77);
    qry_addr1 = 5'd3;
    #1;
    chk("fl_cdb_valid", 64'(cdb_valid), 64'd1);
    chk("fl_reg_wv", 64'(Reg_writevalid), 64'd0);
    chk("fl_ready", 64'(src_ready), 64'd0);
    step();
    idle();
    qry_addr1 = 5'd3;
    qry_addr2 = 5'd7;
    #1;
    chk("fl_x3_free", 64'(qry_busy1), 64'd0);
    chk("fl_x7_free", 64'(qry_busy2), 64'd0);
    chk("fl_s1_clear", 64'(cdb_valid), 64'd0);
    step();

    // asynchronous reset mid-broadcast
    issue(5'd9, 4'd10);
    step();
    idle();
    set_src(2, 4'd10, 32'h99);
    step();
    idle();
    set_src(0, 4'd1, 32'h11);
    qry_addr1 = 5'd9;
    #1 chk("ar_pre_valid", 64'(cdb_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("ar_ready", 64'(src_ready), 64'd0);
    chk("ar_busy", 64'(qry_busy1), 64'd0);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    idle();

    // random traffic against the model
    for (int it = 0; it < 400; it++) begin
      src_valid   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        src_tag[i*TW +: TW]  = TW'($urandom_range(0, 15));
        src_data[i*XW +: XW] = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd    = 5'($urandom_range(0, 31));
      issue_tag   = TW'($urandom_range(0, 15));
      if (m_s1v && int'(issue_tag) == m_s1tag) issue_tag = issue_tag + 1'b1;
      flush       = ($urandom_range(0, 15) == 0);
      qry_addr1   = 5'($urandom_range(0, 31));
      qry_addr2   = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
